// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage plus a carry flip-flop, LSB first.
// start is sampled in IDLE; done pulses one cycle after the last bit is summed.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_c;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic             w_z;
  logic             w_co;
  logic             w_last;
  logic [WIDTH-1:0] w_sum_shift;

  // Full-adder cell on the current LSBs and the carry register.
  assign w_z    = r_a[0] ^ r_b[0] ^ r_c;
  assign w_co   = (r_a[0] & r_b[0]) | (r_a[0] & r_c) | (r_b[0] & r_c);
  assign w_last = (r_cnt == CW'(WIDTH - 1));
  // Written as shift/or so that WIDTH=1 needs no special-case slice.
  assign w_sum_shift = (r_sum >> 1) | (WIDTH'(w_z) << (WIDTH - 1));

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = SHIFT;
      SHIFT:   if (w_last) w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= (w_state_next == SHIFT);
      r_done  <= (w_state_next == DONE);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_a   <= a;
            r_b   <= b;
            r_c   <= cin;
            r_cnt <= '0;
            r_sum <= '0;
          end
        end
        SHIFT: begin
          r_c   <= w_co;
          r_sum <= w_sum_shift;
          r_a   <= r_a >> 1;
          r_b   <= r_b >> 1;
          r_cnt <= r_cnt + CW'(1);
          // cout only changes on the final bit so it holds through DONE and IDLE.
          if (w_last) r_cout <= w_co;
        end
        default: ;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign sum  = r_sum;
  assign cout = r_cout;
endmodule

// File: tb/tb_serial_adder.sv
// Scoreboard bench for serial_adder: WIDTH=8 directed cases, WIDTH=3 exhaustive,
// WIDTH=1 corner cases. Expected {cout,sum} is queued at start; a monitor pops on done.
module tb_serial_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic       start3 = 1'b0, cin3 = 1'b0, busy3, done3, cout3;
  logic [2:0] a3 = '0, b3 = '0, sum3;
  logic       start1 = 1'b0, cin1 = 1'b0, busy1, done1, cout1;
  logic [0:0] a1 = '0, b1 = '0, sum1;

  serial_adder #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder #(.WIDTH(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .start(start3), .a(a3), .b(b3), .cin(cin3),
    .busy(busy3), .done(done3), .sum(sum3), .cout(cout3));
  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .cin(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  int n_cmp = 0;
  int n_err = 0;
  logic [8:0] q8[$];
  logic [3:0] q3[$];
  logic [1:0] q1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else
      $display("ok   %s: %0h", name, act);
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: done with empty scoreboard, got %0h, expected no done", name, act);
  endtask

  task automatic monitor();
    logic [8:0] e8;
    logic [3:0] e3;
    logic [1:0] e1;
    forever begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        chk("w8_done_busy_excl", busy8, 0);
        if (q8.size() == 0) unexpected("w8_unexpected_done", {cout8, sum8});
        else begin e8 = q8.pop_front(); chk("w8_result", {cout8, sum8}, e8); end
      end
      if (done3 === 1'b1) begin
        if (q3.size() == 0) unexpected("w3_unexpected_done", {cout3, sum3});
        else begin e3 = q3.pop_front(); chk("w3_result", {cout3, sum3}, e3); end
      end
      if (done1 === 1'b1) begin
        if (q1.size() == 0) unexpected("w1_unexpected_done", {cout1, sum1});
        else begin e1 = q1.pop_front(); chk("w1_result", {cout1, sum1}, e1); end
      end
    end
  endtask

  // One WIDTH=8 operation; operands are scrambled after acceptance.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                     input logic [8:0] exp);
    int k;
    @(negedge clk);
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    q8.push_back(exp);
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = ~b; cin8 = ~c;
    k = 0;
    while (busy8 === 1'b1 && k < 20) begin
      k++;
      @(negedge clk);
    end
    chk("w8_busy_cycles", k, 8);
    chk("w8_done_latency", done8, 1);
    @(negedge clk);
    chk("w8_done_one_cycle", done8, 0);
    chk("w8_hold_sum", sum8, exp[7:0]);
    chk("w8_hold_cout", cout8, exp[8]);
  endtask

  task automatic op3(input logic [2:0] a, input logic [2:0] b, input logic c);
    int k;
    @(negedge clk);
    a3 = a; b3 = b; cin3 = c; start3 = 1'b1;
    q3.push_back(4'(a) + 4'(b) + 4'(c));
    @(negedge clk);
    start3 = 1'b0;
    k = 0;
    while (done3 !== 1'b1 && k < 10) begin
      k++;
      @(negedge clk);
    end
    if (k >= 10) chk("w3_timeout", done3, 1);
  endtask

  task automatic op1(input logic a, input logic b, input logic c, input logic [1:0] exp);
    int k;
    @(negedge clk);
    a1 = a; b1 = b; cin1 = c; start1 = 1'b1;
    q1.push_back(exp);
    @(negedge clk);
    start1 = 1'b0;
    k = 0;
    while (done1 !== 1'b1 && k < 10) begin
      k++;
      @(negedge clk);
    end
    if (k >= 10) chk("w1_timeout", done1, 1);
  endtask

  initial begin
    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_busy", busy8, 0);
    chk("rst_done", done8, 0);
    chk("rst_sum", sum8, 0);
    chk("rst_cout", cout8, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    op8(8'h5A, 8'h33, 1'b0, 9'h08D);
    op8(8'hFF, 8'hFF, 1'b1, 9'h1FF);
    op8(8'h00, 8'h00, 1'b0, 9'h000);

    // Second start mid-operation must be ignored.
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    q8.push_back(9'h030);
    @(negedge clk);
    start8 = 1'b0;
    repeat (2) @(negedge clk);
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    for (int i = 0; i < 20 && done8 !== 1'b1; i++) @(negedge clk);
    chk("w8_ignored_start_done", done8, 1);
    repeat (15) @(negedge clk);

    op8(8'hFF, 8'h01, 1'b0, 9'h100);

    // Async reset mid-operation: outputs clear at once, no done follows.
    @(negedge clk);
    a8 = 8'h77; b8 = 8'h11; cin8 = 1'b0; start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_busy", busy8, 0);
    chk("abort_done", done8, 0);
    chk("abort_sum", sum8, 0);
    chk("abort_cout", cout8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_idle_busy", busy8, 0);
    op8(8'h01, 8'h01, 1'b0, 9'h002);

    for (int ia = 0; ia < 8; ia++)
      for (int ib = 0; ib < 8; ib++)
        for (int ic = 0; ic < 2; ic++)
          op3(3'(ia), 3'(ib), 1'(ic));

    op1(1'b1, 1'b1, 1'b1, 2'b11);
    op1(1'b1, 1'b0, 1'b0, 2'b01);
    op1(1'b1, 1'b1, 1'b0, 2'b10);
    op1(1'b0, 1'b0, 1'b0, 2'b00);

    repeat (5) @(negedge clk);
    chk("w8_queue_drained", q8.size(), 0);
    chk("w3_queue_drained", q3.size(), 0);
    chk("w1_queue_drained", q1.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
